// File: rtl/mem_if_pkg.sv
// Shared types and constants for the main-memory initiator port.
package mem_if_pkg;

    localparam int unsigned DEFAULT_ADDR_W = 9;
    localparam int unsigned DEFAULT_DATA_W = 32;
    localparam int unsigned RAM_DEPTH      = 512;

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

    typedef enum logic [2:0] {
        BOOT,
        IDLE,
        SETUP,
        ACCESS,
        HOLD
    } state_e;

endpackage

// File: rtl/mem_wait_cnt.sv
// 4-bit loadable down-counter with zero flag; times both the boot window and access strobes.
module mem_wait_cnt #(
    parameter logic [3:0] RST_VAL = 4'd0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic       zero
);

    logic [3:0] cnt_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= RST_VAL;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != 4'd0)) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    assign zero = (cnt_q == 4'd0);

endmodule

// File: rtl/mem_access_ctrl.sv
// Main-memory initiator: latches MAR/MDR, sequences RAM strobes, returns read data with done.
// Define MEM_BOOT_EN to add the post-reset ram_start preload window.
module mem_access_ctrl
    import mem_if_pkg::*;
#(
    parameter int unsigned ADDR_W      = DEFAULT_ADDR_W,
    parameter int unsigned DATA_W      = DEFAULT_DATA_W,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned BOOT_CYCLES = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              ram_r,
    output logic              ram_w,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              ram_start
);

`ifdef MEM_BOOT_EN
    localparam state_e RESET_STATE = BOOT;
    localparam logic   BOOT_ON     = 1'b1;
`else
    localparam state_e RESET_STATE = IDLE;
    localparam logic   BOOT_ON     = 1'b0;
`endif

    state_e     state_q, state_d;
    logic       op_q;
    logic       cnt_load, cnt_dec, cnt_zero;
    logic [3:0] cnt_load_val;

    // Counter comes out of reset already holding the boot window length.
    mem_wait_cnt #(
        .RST_VAL (4'(BOOT_CYCLES - 1))
    ) u_wait_cnt (
        .clock    (clock),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d      = state_q;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        cnt_load_val = 4'(WAIT_CYCLES - 1);
        case (state_q)
            BOOT: begin
                if (cnt_zero) state_d = IDLE;
                else          cnt_dec = 1'b1;
            end
            IDLE: begin
                if (req) state_d = SETUP;
            end
            SETUP: begin
                state_d  = ACCESS;
                cnt_load = 1'b1;
            end
            ACCESS: begin
                if (cnt_zero) state_d = HOLD;
                else          cnt_dec = 1'b1;
            end
            HOLD:    state_d = IDLE;
            default: state_d = RESET_STATE;
        endcase
    end

    // Outputs are decoded from the next state so every one of them is a flop.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= RESET_STATE;
            op_q     <= OP_RD;
            busy     <= BOOT_ON;
            done     <= 1'b0;
            rdata    <= '0;
            ram_r    <= 1'b0;
            ram_w    <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
        end else begin
            state_q <= state_d;
            busy    <= (state_d != IDLE);
            done    <= (state_d == HOLD);
            ram_r   <= (state_d == ACCESS) && (op_q == OP_RD);
            ram_w   <= (state_d == ACCESS) && (op_q == OP_WR);
            if ((state_q == IDLE) && req) begin
                ram_addr <= addr_in;
                op_q     <= we;
                if (we) ram_din <= wdata;
            end
            if ((state_q == ACCESS) && cnt_zero && (op_q == OP_RD)) begin
                rdata <= ram_dout;
            end
        end
    end

`ifdef MEM_BOOT_EN
    logic start_q;

    always_ff @(posedge clock) begin
        if (reset) start_q <= 1'b1;
        else       start_q <= (state_d == BOOT);
    end

    assign ram_start = start_q;
`else
    assign ram_start = 1'b0;
`endif

endmodule
